// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// clear/run state encoding and the hardwired zero register address.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port of regfile_mp. The write-first bypass is built
// when REGFILE_MP_BYPASS_EN is defined; otherwise the port is read-first.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NWR  = 1,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     mem_data_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]     rd_data_o
);

    logic [XLEN-1:0] rd_data_d;
    logic [XLEN-1:0] rd_data_q;
    logic            is_zero;

    assign is_zero = (rd_addr_i == AW'(ZERO_REG));

`ifdef REGFILE_MP_BYPASS_EN
    // Later ports override earlier ones so port 1 wins a double match.
    always_comb begin
        rd_data_d = mem_data_i;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                rd_data_d = wr_data_i[j*XLEN +: XLEN];
            end
        end
        if (is_zero) begin
            rd_data_d = '0;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

    always_comb begin
        rd_data_d = is_zero ? '0 : mem_data_i;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (run_i && rd_en_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired zero register and a
// sequential post-reset clear (ready rises once addresses 1..NREGS-1 are zeroed).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data
);

    rf_state_e       state_q;
    logic [AW-1:0]   ptr_q;
    logic            ready_q;
    logic [XLEN-1:0] mem [NREGS];
    logic            run;

    assign run   = (state_q == ST_RUN);
    assign ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == AW'(NREGS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // No reset on the array; later write ports override earlier ones.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[ptr_q] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] mem_data;
        assign mem_data = mem[rd_addr[i*AW +: AW]];

        regfile_rdport #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
        ) u_rdport (
            .clk        (clk),
            .rst_n      (rst_n),
            .run_i      (run),
            .rd_en_i    (rd_en),
            .rd_addr_i  (rd_addr[i*AW +: AW]),
            .mem_data_i (mem_data),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .rd_data_o  (rd_data[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic                ready;
    logic                rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;

    int total;
    int bad;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready   (ready),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    logic [XLEN-1:0] exp_byp;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_rd(1'b0, '0, '0);
        set_wr(2'b00, '0, '0, '0, '0);
        #12;
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_rd0", rd_data[31:0], 32'h0);
        check("reset_rd1", rd_data[63:32], 32'h0);

        // release between edges, then count edges to ready
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            check($sformatf("clear_ready_e%0d", e), {31'b0, ready}, (e == 31) ? 32'h1 : 32'h0);
        end

        for (int a = 1; a <= 31; a++) begin
            set_rd(1'b1, AW'(a), AW'(32 - a));
            tick();
            check($sformatf("cleared_rd0_a%0d", a), rd_data[31:0], 32'h0);
            check($sformatf("cleared_rd1_a%0d", 32 - a), rd_data[63:32], 32'h0);
        end
        set_rd(1'b0, '0, '0);

        // basic write then read with zero register on port 1
        set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd5, 5'd0);
        tick();
        check("wr5_rd0", rd_data[31:0], 32'hDEADBEEF);
        check("wr5_rd1_zero", rd_data[63:32], 32'h0);

        // write to register 0 is discarded
        set_rd(1'b0, '0, '0);
        set_wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd0, 5'd5);
        tick();
        check("wr0_rd0", rd_data[31:0], 32'h0);
        check("wr0_keep5", rd_data[63:32], 32'hDEADBEEF);

        // same-address conflict: port 1 wins
        set_rd(1'b0, '0, '0);
        set_wr(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF);
        tick();
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd7, 5'd5);
        tick();
        check("conflict_rd7", rd_data[31:0], 32'h5555FFFF);
        check("conflict_keep5", rd_data[63:32], 32'hDEADBEEF);

        // two distinct writes on one edge
        set_rd(1'b0, '0, '0);
        set_wr(2'b11, 5'd10, 32'h10101010, 5'd11, 32'h11111111);
        tick();
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd11, 5'd10);
        tick();
        check("dual_rd11", rd_data[31:0], 32'h11111111);
        check("dual_rd10", rd_data[63:32], 32'h10101010);

        // rd_en low holds previous data
        set_rd(1'b0, 5'd5, 5'd7);
        tick();
        check("hold_rd0", rd_data[31:0], 32'h11111111);
        check("hold_rd1", rd_data[63:32], 32'h10101010);

        // read-during-write on address 9
        set_wr(2'b01, 5'd9, 32'h1, 5'd0, 32'h0);
        tick();
        set_wr(2'b01, 5'd9, 32'h2, 5'd0, 32'h0);
        set_rd(1'b1, 5'd9, 5'd0);
        tick();
`ifdef REGFILE_MP_BYPASS_EN
        exp_byp = 32'h2;
`else
        exp_byp = 32'h1;
`endif
        check("rdw_same_edge", rd_data[31:0], exp_byp);
        check("rdw_zero_port", rd_data[63:32], 32'h0);
        set_wr(2'b00, '0, '0, '0, '0);
        tick();
        check("rdw_next_read", rd_data[31:0], 32'h2);

        // mid-run reset pulse
        set_rd(1'b0, '0, '0);
        set_wr(2'b01, 5'd3, 32'h0000CAFE, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd3, 5'd7);
        tick();
        check("pre_rst_rd3", rd_data[31:0], 32'h0000CAFE);
        check("pre_rst_ready", {31'b0, ready}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'h0);
        check("midrst_rd0", rd_data[31:0], 32'h0);
        check("midrst_rd1", rd_data[63:32], 32'h0);
        #2;
        rst_n = 1'b1;
        set_wr(2'b11, 5'd3, 32'h00000BAD, 5'd12, 32'h00000077);
        set_rd(1'b1, 5'd3, 5'd12);
        for (int e = 1; e <= 31; e++) begin
            tick();
            check($sformatf("reclear_ready_e%0d", e), {31'b0, ready}, (e == 31) ? 32'h1 : 32'h0);
            check($sformatf("reclear_rd0_e%0d", e), rd_data[31:0], 32'h0);
        end
        set_wr(2'b00, '0, '0, '0, '0);
        set_rd(1'b1, 5'd3, 5'd12);
        tick();
        check("post_clear_rd3", rd_data[31:0], 32'h0);
        check("post_clear_rd12", rd_data[63:32], 32'h0);
        set_rd(1'b1, 5'd5, 5'd9);
        tick();
        check("post_clear_rd5", rd_data[31:0], 32'h0);
        check("post_clear_rd9", rd_data[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read file in the datapath.
- Sits between decode (read ports) and writeback (write ports).
- Adds:
  - configurable width, depth, read-port count and write-port count
  - a hardwired zero register
  - a sequential post-reset clear with a ready flag
  - defined write-port priority

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 4.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once the post-reset clear is complete.
- rd_en  in  1  read strobe shared by all read ports.
- rd_addr  in  NRD*AW  packed read addresses; port i occupies [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed registered read data; port i occupies [i*XLEN +: XLEN].
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data = 0, ready = 0.
  - FSM to CLEAR, clear pointer = 1.
  - Array contents are not reset directly, so the array stays BRAM-inferable.
- FSM states: CLEAR, RUN.
  - CLEAR: each rising edge writes 0 to array[ptr], then ptr++.
  - On the edge that clears NREGS-1, go to RUN and set ready = 1.
  - ready therefore rises NREGS-1 edges after rst_n deasserts; 31 edges at the defaults.
- In CLEAR:
  - wr_en and rd_en are ignored.
  - rd_data holds 0.
- In RUN, writes:
  - On an edge with wr_en[j] high and wr_addr j != 0, array[wr_addr j] <= wr_data j.
  - Writes to address 0 are discarded.
- In RUN, reads:
  - On an edge with rd_en high, each port i loads rd_data i <= (rd_addr i == 0) ? 0 : array[rd_addr i].
  - Read latency is 1 cycle.
  - rd_en low: rd_data holds its previous value.
- Write conflict: both write ports target the same nonzero address on the same edge -> port 1 wins; port 0's data is lost.
- Read-during-write to the same address, same edge: see the optional feature below.
- Reset asserted mid-RUN:
  - ready drops immediately and the clear restarts from address 1.
  - Array contents are undefined until the new clear completes.
- Register 0 always reads 0, independent of array contents.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined (write-first):
  - A read of address A on the same edge as an accepted write to A returns the written data.
  - With two matching writes, port 1's data is returned.
  - The bypass never applies to address 0.
- Undefined (read-first):
  - The read returns the pre-write contents; the new value is visible from the next read.
  - This gives a pure BRAM read path.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants
  - the FSM state encoding (ST_CLEAR, ST_RUN)
  - the ZERO_REG address constant
- Natural sub-module: regfile_rdport, one read port, instantiated NRD times in a generate loop.
  - Contains the address-0 mux, the bypass compare against the wr_* buses, and the output register.
- The top level owns the array, the write logic and the clear FSM.

Test Plan:
- Reset release with rst_n=0->1, then idle → ready = 0 for 30 edges and 1 after edge 31; reading addresses 1..31 returns 0.
- Write 0xDEADBEEF to address 5, then next cycle read port 0 addr 5 and port 1 addr 0 with rd_en=1 → one edge later rd_data0 = 0xDEADBEEF, rd_data1 = 0.
- Write 0x12345678 to address 0, then read address 0 → 0; no other register changes.
- NWR=2: port 0 writes 0xAAAA0000 to address 7 and port 1 writes 0x5555FFFF to address 7 on the same edge → a later read of address 7 returns 0x5555FFFF.
- Address 9 holds 0x1; write 0x2 to 9 while reading 9 on the same edge → 0x2 with REGFILE_MP_BYPASS_EN, 0x1 without; the next read returns 0x2 in both builds.
- Mid-run pulse of rst_n low for 3 ns after writing 0xCAFE to address 3 → ready and rd_data go to 0 immediately; after 31 edges, ready = 1 and address 3 reads 0; writes issued during CLEAR have no effect.
